alu_shift_sequencer: RTL and testbench

//   Multi-position shift controller that sits upstream of, and drives, the
//   32-bit single-position shift datapath of the ALU.
//   - Accepts an operand, shift amount, direction and arithmetic flag over a

---
 rtl/alu_shift_sequencer.sv | 118 +++++++++++
 tb/tb_alu_shift_sequencer.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_shift_sequencer.sv
// Multi-position shifter: one bit position per clock, handshaked in and out.
// Optional rotate support is enabled by defining ALU_SHIFT_ROTATE_EN.
module alu_shift_sequencer #(
  parameter int WIDTH = 32,
  parameter int AMT_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [AMT_W-1:0] in_amt,
  input  logic             in_dir,
  input  logic             in_arith,
  input  logic             in_rot,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_carry,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

`ifdef ALU_SHIFT_ROTATE_EN
  localparam bit ROT_EN = 1'b1;
`else
  // Rotate request is still captured, but masked off so every op is a plain shift.
  localparam bit ROT_EN = 1'b0;
`endif

  state_t           state;
  logic [AMT_W-1:0] cnt;
  logic             dir_q;
  logic             arith_q;
  logic             rot_q;
  logic [WIDTH:0]   step_p0;

  // Single-position step: returns {exiting bit, shifted word}.
  function automatic logic [WIDTH:0] shift_step(
    input logic [WIDTH-1:0] v,
    input logic             dir,
    input logic             arith,
    input logic             rot
  );
    logic exit_bit;
    logic fill;
    exit_bit = dir ? v[0] : v[WIDTH-1];
    if (rot)
      fill = exit_bit;
    else if (dir && arith)
      fill = v[WIDTH-1];
    else
      fill = 1'b0;
    if (dir)
      shift_step = {exit_bit, fill, v[WIDTH-1:1]};
    else
      shift_step = {exit_bit, v[WIDTH-2:0], fill};
  endfunction

  assign step_p0 = shift_step(out_data, dir_q, arith_q, rot_q & ROT_EN);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      out_data  <= '0;
      out_carry <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            out_data  <= in_data;
            out_carry <= 1'b0;
            cnt       <= in_amt;
            dir_q     <= in_dir;
            arith_q   <= in_arith;
            rot_q     <= in_rot;
            in_ready  <= 1'b0;
            busy      <= 1'b1;
            if (in_amt != '0) begin
              state <= SHIFT;
            end else begin
              state     <= DONE;
              out_valid <= 1'b1;
            end
          end
        end
        SHIFT: begin
          {out_carry, out_data} <= step_p0;
          cnt <= cnt - AMT_W'(1);
          if (cnt == AMT_W'(1)) begin
            state     <= DONE;
            out_valid <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_shift_sequencer.sv
// Bench for alu_shift_sequencer: directed vector table, corner sequences and
// randomized ops against a plain-arithmetic shift model.
module tb_alu_shift_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic [4:0]  in_amt;
  logic        in_dir;
  logic        in_arith;
  logic        in_rot;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_carry;
  logic        busy;

  int n_tests = 0;
  int n_fail  = 0;

  alu_shift_sequencer #(.WIDTH(32), .AMT_W(5)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_amt(in_amt), .in_dir(in_dir), .in_arith(in_arith), .in_rot(in_rot),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_carry(out_carry), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] d;
    logic [4:0]  a;
    logic        dir;
    logic        arith;
    logic        rot;
    logic [31:0] exp_d;
    logic        exp_c;
  } vec_t;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Whole-operation reference: {carry, result} from plain shift arithmetic.
  function automatic logic [32:0] model(input logic [31:0] d, input int a,
                                        input logic dir, input logic arith, input logic rot);
    logic [31:0] r;
    logic        c;
    logic        rot_on;
`ifdef ALU_SHIFT_ROTATE_EN
    rot_on = rot;
`else
    rot_on = 1'b0 & rot;
`endif
    if (a == 0) return {1'b0, d};
    if (!dir) begin
      c = d[32-a];
      r = d << a;
      if (rot_on) r = r | (d >> (32 - a));
    end else begin
      c = d[a-1];
      if (rot_on)     r = (d >> a) | (d << (32 - a));
      else if (arith) r = $signed(d) >>> a;
      else            r = d >> a;
    end
    return {c, r};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one op, wait for the result, hold it 'hold' cycles, then take it.
  task automatic do_op(input logic [31:0] d, input logic [4:0] a, input logic dr,
                       input logic ar, input logic ro, input int hold,
                       output logic [31:0] od, output logic oc, output int lat);
    int w;
    w = 0;
    while (!in_ready && w < 100) begin tick(); w++; end
    in_valid = 1'b1; in_data = d; in_amt = a; in_dir = dr; in_arith = ar; in_rot = ro;
    tick();
    in_valid = 1'b0;
    in_data  = $urandom;
    lat = 1;
    while (!out_valid && lat < 100) begin tick(); lat++; end
    od = out_data;
    oc = out_carry;
    for (int h = 0; h < hold; h++) tick();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  vec_t        vecs[8];
  logic [31:0] od;
  logic        oc;
  int          lat;
  logic [32:0] m;
  logic [31:0] held_d;
  logic        held_c;
  bit          stable;
  bit          seen;

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_amt = '0; in_dir = 1'b0;
    in_arith = 1'b0; in_rot = 1'b0; out_ready = 1'b0;

    vecs[0] = '{32'h8000_0001, 5'd1,  1'b0, 1'b0, 1'b0, 32'h0000_0002, 1'b1};
    vecs[1] = '{32'h8000_0000, 5'd31, 1'b1, 1'b1, 1'b0, 32'hFFFF_FFFF, 1'b0};
    vecs[2] = '{32'h1234_5678, 5'd0,  1'b0, 1'b0, 1'b0, 32'h1234_5678, 1'b0};
    vecs[3] = '{32'hF000_0000, 5'd4,  1'b1, 1'b0, 1'b0, 32'h0F00_0000, 1'b0};
    vecs[4] = '{32'hC000_0001, 5'd2,  1'b0, 1'b1, 1'b0, 32'h0000_0004, 1'b1};
    vecs[5] = '{32'hFFFF_FFFF, 5'd31, 1'b0, 1'b0, 1'b0, 32'h8000_0000, 1'b1};
    vecs[6] = '{32'h8000_0010, 5'd5,  1'b1, 1'b0, 1'b0, 32'h0400_0000, 1'b1};
`ifdef ALU_SHIFT_ROTATE_EN
    vecs[7] = '{32'h0000_0001, 5'd1,  1'b1, 1'b0, 1'b1, 32'h8000_0000, 1'b1};
`else
    vecs[7] = '{32'h0000_0001, 5'd1,  1'b1, 1'b0, 1'b1, 32'h0000_0000, 1'b1};
`endif

    tick(); tick();
    rst = 1'b0;
    check("reset_in_ready", in_ready, 1);
    check("reset_out_valid", out_valid, 0);
    check("reset_out_data", out_data, 0);
    check("reset_out_carry", out_carry, 0);
    check("reset_busy", busy, 0);

    // Directed vectors
    foreach (vecs[i]) begin
      do_op(vecs[i].d, vecs[i].a, vecs[i].dir, vecs[i].arith, vecs[i].rot, 0, od, oc, lat);
      check($sformatf("vec%0d_data", i), od, vecs[i].exp_d);
      check($sformatf("vec%0d_carry", i), oc, vecs[i].exp_c);
      check($sformatf("vec%0d_latency", i), lat, (vecs[i].a == 0) ? 1 : vecs[i].a + 1);
    end

    // Reset mid-shift drops the operation
    in_valid = 1'b1; in_data = 32'hA5A5_A5A5; in_amt = 5'd20; in_dir = 1'b0;
    in_arith = 1'b0; in_rot = 1'b0;
    tick();
    in_valid = 1'b0;
    for (int k = 0; k < 5; k++) tick();
    check("midshift_busy", busy, 1);
    check("midshift_in_ready", in_ready, 0);
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    check("rst_mid_out_valid", out_valid, 0);
    check("rst_mid_in_ready", in_ready, 1);
    check("rst_mid_out_data", out_data, 0);
    check("rst_mid_busy", busy, 0);
    seen = 1'b0;
    for (int k = 0; k < 30; k++) begin tick(); if (out_valid) seen = 1'b1; end
    check("rst_mid_no_result", seen, 0);

    // Backpressure in DONE, with junk requests offered while busy
    in_valid = 1'b1; in_data = 32'h0000_FFFF; in_amt = 5'd8; in_dir = 1'b0;
    tick();
    in_data = 32'hDEAD_BEEF; in_amt = 5'd3; in_dir = 1'b1;
    lat = 1;
    while (!out_valid && lat < 100) begin tick(); lat++; end
    in_valid = 1'b0;
    check("bp_latency", lat, 9);
    check("bp_data", out_data, 32'h00FF_FF00);
    check("bp_carry", out_carry, 0);
    held_d = out_data; held_c = out_carry;
    stable = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (!out_valid || in_ready || out_data !== held_d || out_carry !== held_c)
        stable = 1'b0;
    end
    check("bp_stable", stable, 1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("bp_release_out_valid", out_valid, 0);
    check("bp_release_in_ready", in_ready, 1);
    check("bp_release_busy", busy, 0);

    // Randomized ops against the model
    for (int n = 0; n < 200; n++) begin
      logic [31:0] d;
      logic [4:0]  a;
      logic        dr, ar, ro;
      d  = $urandom;
      a  = 5'($urandom_range(0, 31));
      dr = 1'($urandom_range(0, 1));
      ar = 1'($urandom_range(0, 1));
      ro = 1'($urandom_range(0, 1));
      m  = model(d, int'(a), dr, ar, ro);
      do_op(d, a, dr, ar, ro, $urandom_range(0, 2), od, oc, lat);
      check($sformatf("rand%0d_data d=%0h a=%0d dir=%0b ar=%0b rot=%0b", n, d, a, dr, ar, ro),
            od, m[31:0]);
      check($sformatf("rand%0d_carry", n), oc, m[32]);
      check($sformatf("rand%0d_latency", n), lat, (a == 0) ? 1 : int'(a) + 1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
